// File: rtl/udma_eth_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : udma_eth_tx_framer
// Purpose  : Cuts the uDMA TX byte stream into fixed-length frames, flags the
//            last byte and optionally zero-pads short frames to MIN_FRAME.
// Revision : 1.0 - initial release
// ============================================================================
module udma_eth_tx_framer #(
    parameter int LEN_WIDTH = 16,
    parameter int MIN_FRAME = 60
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 cfg_en_i,
    input  logic [LEN_WIDTH-1:0] cfg_frame_len_i,
    input  logic                 cfg_pad_en_i,
    input  logic [7:0]           s_data_i,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    output logic [7:0]           m_data_o,
    output logic                 m_last_o,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic                 busy_o,
    output logic                 frame_done_o,
    output logic [15:0]          frame_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_PAD  = 2'd2
    } state_t;

    localparam logic [LEN_WIDTH-1:0] c_min_frame = LEN_WIDTH'(MIN_FRAME);
    localparam logic [LEN_WIDTH-1:0] c_min_last  = LEN_WIDTH'(MIN_FRAME - 1);
    localparam logic [LEN_WIDTH-1:0] c_len_zero  = '0;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [LEN_WIDTH-1:0] r_len;
    logic                 r_pad;
    logic [LEN_WIDTH-1:0] r_cnt;
    logic                 r_frame_done;
    logic [15:0]          r_frame_cnt;

    logic                 w_start;
    logic                 w_beat;
    logic                 w_frame_end;
    logic                 w_data_last;
    logic                 w_no_pad;

    assign w_data_last = (r_cnt == r_len - 1'b1);
    assign w_no_pad    = !r_pad || (r_len >= c_min_frame);

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_beat      = 1'b0;
        w_frame_end = 1'b0;
        s_ready_o   = 1'b0;
        m_valid_o   = 1'b0;
        m_data_o    = 8'h00;
        m_last_o    = 1'b0;
        busy_o      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Start cycle moves no data: one bubble per frame
                if (cfg_en_i && s_valid_i && (cfg_frame_len_i != c_len_zero)) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                busy_o    = 1'b1;
                m_data_o  = s_data_i;
                m_valid_o = s_valid_i;
                s_ready_o = m_ready_i;
                m_last_o  = w_data_last && w_no_pad;
                w_beat    = s_valid_i && m_ready_i;
                if (w_beat && w_data_last) begin
                    if (w_no_pad) begin
                        w_frame_end = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_PAD;
                    end
                end
            end
            S_PAD: begin
                busy_o    = 1'b1;
                m_valid_o = 1'b1;
                m_last_o  = (r_cnt == c_min_last);
                w_beat    = m_ready_i;
                if (w_beat && m_last_o) begin
                    w_frame_end = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_pad        <= 1'b0;
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= w_frame_end;
            if (w_start) begin
                r_len <= cfg_frame_len_i;
                r_pad <= cfg_pad_en_i;
                r_cnt <= '0;
            end else if (w_beat) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_frame_end) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign frame_done_o = r_frame_done;
    assign frame_cnt_o  = r_frame_cnt;

endmodule
`default_nettype wire
